// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encodings and the per-operation control flags latched at issue.
package mdu_iter_pkg;

  localparam int MD_OPER_W = 2;

  localparam logic [MD_OPER_W-1:0] EXE_MD_MULT = 2'd0;
  localparam logic [MD_OPER_W-1:0] EXE_MD_DIV  = 2'd1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Flags captured when an operation is accepted; they steer the iteration
  // and the final sign correction.
  typedef struct packed {
    logic is_div;
    logic neg_q;     // product / quotient must be negated
    logic neg_r;     // remainder takes the dividend's sign
    logic div_zero;  // divisor was zero
  } md_ctrl_t;

endpackage

// File: rtl/mdu_if.sv
// EXE-stage <-> multiply/divide unit interface: issue, abort, HI/LO moves
// and the status/result outputs.
interface mdu_if
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [MD_OPER_W-1:0] oper;
  logic                 sign;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 flush;
  logic                 hi_we;
  logic                 lo_we;
  logic [WIDTH-1:0]     wdata;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;

  modport master (
    output start, oper, sign, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, oper, sign, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Radix-2 iterative multiply/divide unit owning the HI/LO registers.
// One product or quotient bit per clock over a shared 2*WIDTH accumulator.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst_n,
  mdu_if.slave bus
);

  md_state_e              state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [2*WIDTH-1:0]     acc;
  logic [WIDTH-1:0]       opd;
  md_ctrl_t               ctrl;
  logic [WIDTH-1:0]       hi_r, lo_r;

  logic                   accept;
  logic                   last_iter;

  // Issue-time operand preparation
  logic                   a_neg, b_neg, is_div, div_zero;
  logic [WIDTH-1:0]       a_abs, b_abs;

  // Iteration datapath
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next;
  logic [WIDTH:0]         rem_sh;
  logic                   rem_ge;
  logic [WIDTH-1:0]       rem_sub;
  logic [2*WIDTH-1:0]     div_next;

  // Sign-corrected results
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       fix_hi, fix_lo;

  assign accept    = (state == MD_IDLE) && bus.start && !bus.flush;
  assign last_iter = (cnt == CNT_W'(1));

  assign a_neg    = bus.sign & bus.a[WIDTH-1];
  assign b_neg    = bus.sign & bus.b[WIDTH-1];
  assign a_abs    = a_neg ? -bus.a : bus.a;
  assign b_abs    = b_neg ? -bus.b : bus.b;
  assign is_div   = (bus.oper == EXE_MD_DIV);
  assign div_zero = is_div && (bus.b == '0);

  // Shift-add: conditionally add the multiplicand into the upper half,
  // then shift the whole product right with the carry moving into the MSB.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opd};
  assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                           : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};

  // Restoring division: upper half is the partial remainder, lower half holds
  // the remaining dividend bits and collects quotient bits from the right.
  // When the subtraction is taken the result is below the divisor, so the
  // WIDTH-bit difference is exact.
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, opd});
  assign rem_sub  = rem_sh[WIDTH-1:0] - opd;
  assign div_next = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]),
                     acc[WIDTH-2:0], rem_ge};

  assign prod_fix = ctrl.neg_q ? -acc : acc;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (ctrl.is_div) begin
      // A zero divisor yields all-ones quotient and the raw dividend as
      // remainder straight out of the iteration; no sign correction.
      fix_hi = acc[2*WIDTH-1:WIDTH];
      fix_lo = acc[WIDTH-1:0];
      if (!ctrl.div_zero) begin
        if (ctrl.neg_r) fix_hi = -acc[2*WIDTH-1:WIDTH];
        if (ctrl.neg_q) fix_lo = -acc[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (accept) state_nxt = MD_CALC;
      MD_CALC: begin
        if (bus.flush)      state_nxt = MD_IDLE;
        else if (last_iter) state_nxt = MD_FIX;
      end
      MD_FIX:  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      opd  <= '0;
      ctrl <= '0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (accept) begin
            cnt           <= CNT_W'(WIDTH);
            ctrl.is_div   <= is_div;
            ctrl.neg_q    <= a_neg ^ b_neg;
            ctrl.neg_r    <= a_neg;
            ctrl.div_zero <= div_zero;
            if (is_div) begin
              acc <= {{WIDTH{1'b0}}, (div_zero ? bus.a : a_abs)};
              opd <= b_abs;
            end else begin
              acc <= {{WIDTH{1'b0}}, b_abs};
              opd <= a_abs;
            end
          end else begin
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        MD_CALC: begin
          cnt <= cnt - CNT_W'(1);
          acc <= ctrl.is_div ? div_next : mul_next;
        end
        MD_FIX: begin
          if (!bus.flush) begin
            hi_r <= fix_hi;
            lo_r <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // Results are forwarded combinationally in the done cycle and committed to
  // HI/LO on the following edge; a flush in FIX suppresses both.
  assign bus.busy = (state != MD_IDLE);
  assign bus.done = (state == MD_FIX) && !bus.flush;
  assign bus.hi   = bus.done ? fix_hi : hi_r;
  assign bus.lo   = bus.done ? fix_lo : lo_r;

endmodule
